uart_rx: RTL and testbench

UART receiver that pairs with the existing `uart_tx`: 8N1 framing, LSB first, idle-high line, runtime-programmable bit period. It resynchronises the asynchronous serial input, qualifies the start bit at mid-bit, samples data and stop bits at bit centres, and presents each received byte on a valid/ready handshake. It sits between the board RX pin and the command/data consumer, and flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state encoding
// and default framing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE  = 3'd0,
        UART_START = 3'd1,
        UART_DATA  = 3'd2,
        UART_STOP  = 3'd3,
        UART_BREAK = 3'd4
    } uart_state_t;

    localparam int DEFAULT_CPB     = 434;
    localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RESET_VALUE, so the output matches the input's idle level out of reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start qualification, centre sampling of data and stop bits,
// a runtime bit period latched per frame, and a valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int CPB_WIDTH  = 13,
    parameter int MIN_CPB    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_serial,
    input  logic [CPB_WIDTH-1:0]  clks_per_bit,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CPB_WIDTH-1:0] MIN_CPB_V = CPB_WIDTH'(MIN_CPB);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(DATA_WIDTH - 1);

    uart_state_t state;
    uart_state_t state_next;

    logic                  rx_s;
    logic [CPB_WIDTH-1:0]  cpb;
    logic [CPB_WIDTH-1:0]  cnt;
    logic [IDX_WIDTH-1:0]  bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  half_hit;
    logic                  full_hit;

    logic capture;
    logic cnt_clr;
    logic cnt_inc;
    logic bit_clr;
    logic shift_en;
    logic stop_good;
    logic stop_fail;
    logic stop_ok;
    logic stop_bad;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_s)
    );

    assign half_hit = (cnt == ((cpb >> 1) - CPB_WIDTH'(1)));
    assign full_hit = (cnt == (cpb - CPB_WIDTH'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UART_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            UART_IDLE:  if (!rx_s)    state_next = UART_START;
            UART_START: if (half_hit) state_next = rx_s ? UART_IDLE : UART_DATA;
            UART_DATA:  if (full_hit && (bit_idx == LAST_IDX)) state_next = UART_STOP;
            UART_STOP:  if (full_hit) state_next = rx_s ? UART_IDLE : UART_BREAK;
            UART_BREAK: if (rx_s)     state_next = UART_IDLE;
            default:                  state_next = UART_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != UART_IDLE);
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_fail = 1'b0;
        case (state)
            UART_IDLE: begin
                cnt_clr = 1'b1;
                capture = !rx_s;
            end
            UART_START: begin
                if (half_hit) begin
                    cnt_clr = 1'b1;
                    bit_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            UART_DATA: begin
                if (full_hit) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            UART_STOP: begin
                if (full_hit) begin
                    cnt_clr   = 1'b1;
                    stop_good = rx_s;
                    stop_fail = !rx_s;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // The bit period is latched once per frame so a mid-frame change cannot skew sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpb     <= MIN_CPB_V;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (capture) begin
                cpb <= (clks_per_bit < MIN_CPB_V) ? MIN_CPB_V : clks_per_bit;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CPB_WIDTH'(1);
            end
            if (bit_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + IDX_WIDTH'(1);
            end
            if (shift_en) begin
                shift[bit_idx] <= rx_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_ok  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            stop_ok  <= stop_good;
            stop_bad <= stop_fail;
        end
    end

    // Handshake: a byte transfers on every edge where rx_valid and rx_ready are both high.
    // rx_data/rx_valid change only on delivery or transfer; rx_ready is ignored while rx_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= stop_ok && rx_valid && !rx_ready;
            if (stop_ok && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven from a bit-level transmitter task
// and results compared with timings and bytes derived from the framing rules.
module tb_uart_rx;

    localparam int MIN_CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_serial = 1'b1;
    logic [12:0] clks_per_bit = 13'd16;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int passed = 0;
    int total = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk          (clk),
        .rst          (rst),
        .rx_serial    (rx_serial),
        .clks_per_bit (clks_per_bit),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int eff_cpb(input int p);
        return (p < MIN_CPB) ? MIN_CPB : p;
    endfunction

    // Cycles from the falling start edge to rx_valid: 3 to enter START, half a bit to the
    // start sample, nine bits to the stop sample, one more edge to register the result.
    function automatic int exp_latency(input int p);
        int c;
        c = eff_cpb(p);
        return 3 + c / 2 + 9 * c + 1;
    endfunction

    task automatic drive_frame(input logic [7:0] data, input int bit_cyc, input int start_cyc,
                               input int stop_cyc, input logic stop_level);
        rx_serial = 1'b0;
        repeat (start_cyc) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_serial = data[i];
            repeat (bit_cyc) @(posedge clk);
            #1;
        end
        rx_serial = stop_level;
        repeat (stop_cyc) @(posedge clk);
        #1;
    endtask

    task automatic send_watch(input logic [7:0] data, input int bit_cyc, input int start_cyc,
                              input int stop_cyc, input logic stop_level,
                              output int lat, output logic [7:0] got);
        int budget;
        int l;
        logic [7:0] g;
        budget = start_cyc + 8 * bit_cyc + stop_cyc + 4;
        l = -1;
        g = '0;
        fork
            drive_frame(data, bit_cyc, start_cyc, stop_cyc, stop_level);
            begin
                for (int k = 1; k <= budget; k++) begin
                    @(posedge clk);
                    #1;
                    if (rx_valid && (l < 0)) begin
                        l = k;
                        g = rx_data;
                    end
                end
            end
        join
        lat = l;
        got = g;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_serial = 1'b1;
        rx_ready = 1'b0;
        clks_per_bit = 13'd16;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL idle_rx_valid: got %b want 0", rx_valid); else passed++;
    endtask

    task automatic test_clean_frame;
        int lat;
        int f0;
        int o0;
        logic [7:0] got;
        f0 = fe_cnt;
        o0 = ov_cnt;
        rx_ready = 1'b1;
        clks_per_bit = 13'd16;
        send_watch(8'hA5, 16, 16, 16, 1'b1, lat, got);
        total++; if (lat != exp_latency(16)) $display("FAIL clean_latency: got %0d want %0d", lat, exp_latency(16)); else passed++;
        total++; if (got !== 8'hA5) $display("FAIL clean_data: got %h want a5", got); else passed++;
        total++; if (fe_cnt - f0 != 0) $display("FAIL clean_frame_err: got %0d pulses want 0", fe_cnt - f0); else passed++;
        total++; if (ov_cnt - o0 != 0) $display("FAIL clean_overrun: got %0d pulses want 0", ov_cnt - o0); else passed++;
    endtask

    task automatic test_start_glitch;
        logic saw_busy;
        logic saw_valid;
        int lat;
        int f0;
        logic [7:0] got;
        f0 = fe_cnt;
        saw_busy = 1'b0;
        saw_valid = 1'b0;
        rx_serial = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_serial = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            saw_busy = saw_busy | busy;
            saw_valid = saw_valid | rx_valid;
        end
        total++; if (saw_busy !== 1'b1) $display("FAIL glitch_started: busy seen %b want 1", saw_busy); else passed++;
        total++; if (saw_valid !== 1'b0) $display("FAIL glitch_no_valid: rx_valid seen %b want 0", saw_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL glitch_idle: busy %b want 0", busy); else passed++;
        total++; if (fe_cnt - f0 != 0) $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - f0); else passed++;
        send_watch(8'h5A, 16, 16, 16, 1'b1, lat, got);
        total++; if (got !== 8'h5A) $display("FAIL glitch_next_data: got %h want 5a", got); else passed++;
        total++; if (lat != exp_latency(16)) $display("FAIL glitch_next_latency: got %0d want %0d", lat, exp_latency(16)); else passed++;
    endtask

    task automatic test_framing_error;
        int lat;
        int f0;
        int o0;
        logic [7:0] got;
        f0 = fe_cnt;
        o0 = ov_cnt;
        send_watch(8'h3C, 16, 16, 48, 1'b0, lat, got);
        total++; if (lat != -1) $display("FAIL ferr_no_valid: rx_valid seen at cycle %0d want never", lat); else passed++;
        total++; if (fe_cnt - f0 != 1) $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - f0); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL ferr_break_held: busy %b want 1", busy); else passed++;
        total++; if (ov_cnt - o0 != 0) $display("FAIL ferr_overrun: got %0d pulses want 0", ov_cnt - o0); else passed++;
        rx_serial = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL ferr_break_exit: busy %b want 0", busy); else passed++;
        send_watch(8'h81, 16, 16, 16, 1'b1, lat, got);
        total++; if (got !== 8'h81) $display("FAIL ferr_next_data: got %h want 81", got); else passed++;
    endtask

    task automatic test_overrun;
        logic [7:0] frames [2];
        logic model_full;
        int exp_ov;
        int o0;
        logic [7:0] exp;
        frames[0] = 8'h11;
        frames[1] = 8'h22;
        model_full = 1'b0;
        exp_ov = 0;
        o0 = ov_cnt;
        rx_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_frame(frames[i], 16, 16, 16, 1'b1);
            if (model_full && !rx_ready) exp_ov++;
            else begin
                exp_q.push_back(frames[i]);
                model_full = 1'b1;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        total++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid_held: got %b want 1", rx_valid); else passed++;
        total++; if (rx_data !== exp) $display("FAIL ovr_data_kept: got %h want %h", rx_data, exp); else passed++;
        total++; if (ov_cnt - o0 != exp_ov) $display("FAIL ovr_pulses: got %0d want %0d", ov_cnt - o0, exp_ov); else passed++;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (rx_valid !== 1'b0) $display("FAIL ovr_consume: rx_valid %b want 0", rx_valid); else passed++;
    endtask

    task automatic test_same_cycle;
        int lat_e;
        int o0;
        logic [7:0] old_data;
        logic [7:0] new_data;
        logic new_valid;
        rx_ready = 1'b0;
        drive_frame(8'h5E, 16, 16, 16, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        total++; if (rx_data !== 8'h5E) $display("FAIL same_first_data: got %h want 5e", rx_data); else passed++;
        o0 = ov_cnt;
        lat_e = exp_latency(16);
        fork
            drive_frame(8'hC3, 16, 16, 16, 1'b1);
            begin
                repeat (lat_e - 1) @(posedge clk);
                #1;
                old_data = rx_data;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
                new_valid = rx_valid;
                new_data = rx_data;
            end
        join
        total++; if (old_data !== 8'h5E) $display("FAIL same_before_edge: got %h want 5e", old_data); else passed++;
        total++; if (new_valid !== 1'b1) $display("FAIL same_valid_kept: got %b want 1", new_valid); else passed++;
        total++; if (new_data !== 8'hC3) $display("FAIL same_new_data: got %h want c3", new_data); else passed++;
        total++; if (ov_cnt - o0 != 0) $display("FAIL same_no_overrun: got %0d pulses want 0", ov_cnt - o0); else passed++;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (rx_valid !== 1'b0) $display("FAIL same_consume: rx_valid %b want 0", rx_valid); else passed++;
    endtask

    task automatic test_random_frames;
        int lat;
        int c;
        logic [7:0] b;
        logic [7:0] got;
        logic [7:0] exp;
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            c = $urandom_range(8, 24);
            clks_per_bit = 13'(c);
            exp_q.push_back(b);
            send_watch(b, c, c, c, 1'b1, lat, got);
            exp = exp_q.pop_front();
            total++; if (got !== exp) $display("FAIL rand_data[%0d]: got %h want %h cpb %0d", i, got, exp, c); else passed++;
            total++; if (lat != exp_latency(c)) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, exp_latency(c)); else passed++;
        end
    endtask

    task automatic test_clamp_period_change;
        int lat;
        logic [7:0] b;
        logic [7:0] got;
        rx_ready = 1'b1;
        clks_per_bit = 13'd2;
        b = 8'($urandom_range(0, 255));
        // At the minimum period most of the start bit is spent in synchroniser latency,
        // so the transmitter stretches it to keep every sample inside its bit.
        fork
            send_watch(b, eff_cpb(2), eff_cpb(2) + 2, eff_cpb(2), 1'b1, lat, got);
            begin
                repeat (12) @(posedge clk);
                #1;
                clks_per_bit = 13'd16;
            end
        join
        total++; if (got !== b) $display("FAIL clamp_data: got %h want %h", got, b); else passed++;
        total++; if (lat != exp_latency(2)) $display("FAIL clamp_latency: got %0d want %0d", lat, exp_latency(2)); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        int lat;
        logic [7:0] b;
        logic [7:0] got;
        rx_ready = 1'b0;
        clks_per_bit = 13'd16;
        b = 8'($urandom_range(1, 255));
        send_watch(b, 16, 16, 16, 1'b1, lat, got);
        total++; if (got !== b) $display("FAIL rmid_first_data: got %h want %h", got, b); else passed++;
        rx_serial = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) $display("FAIL rmid_in_frame: busy %b want 1", busy); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (rx_valid !== 1'b0) $display("FAIL rmid_rx_valid: got %b want 0", rx_valid); else passed++;
        total++; if (rx_data !== 8'h00) $display("FAIL rmid_rx_data: got %h want 00", rx_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL rmid_frame_err: got %b want 0", frame_err); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL rmid_overrun: got %b want 0", overrun); else passed++;
        rx_serial = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        b = 8'($urandom_range(0, 255));
        send_watch(b, 16, 16, 16, 1'b1, lat, got);
        total++; if (got !== b) $display("FAIL rmid_after_data: got %h want %h", got, b); else passed++;
        total++; if (lat != exp_latency(16)) $display("FAIL rmid_after_latency: got %0d want %0d", lat, exp_latency(16)); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_start_glitch();
        test_framing_error();
        test_overrun();
        test_same_cycle();
        test_random_frames();
        test_clamp_period_change();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
